// File: rtl/mesi_bus_controller.sv
`default_nettype none
// mesi_bus_controller: round-robin shared-bus arbiter and snoop responder for MESI L1s.
// Rev 1.0 - initial release.
module mesi_bus_controller #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req_core,
  input  logic [2*NUM_CORES-1:0]      core_op_in,
  input  logic [ADDR_W*NUM_CORES-1:0] core_addr_in,
  output logic [NUM_CORES-1:0]        grant,
  output logic [2*NUM_CORES-1:0]      snoop_op_out,
  output logic [ADDR_W-1:0]           snoop_addr_out,
  input  logic [NUM_CORES-1:0]        snoop_hit_in,
  input  logic [DATA_W*NUM_CORES-1:0] snoop_data_in,
  input  logic [NUM_CORES-1:0]        flush_in,
  output logic [DATA_W*NUM_CORES-1:0] resp_data_out,
  output logic [2*NUM_CORES-1:0]      resp_hit_out,
  output logic                        l2_rd_req,
  output logic                        l2_wr_en,
  output logic [ADDR_W-1:0]           l2_addr,
  output logic [DATA_W-1:0]           l2_wr_data,
  input  logic                        l2_rd_valid,
  input  logic [DATA_W-1:0]           l2_rd_data,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_CORES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_SNOOP   = 3'd2;
  localparam logic [2:0] S_L2_WAIT = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_UPGR = 2'b01;
  localparam logic [1:0] OP_NONE = 2'b11;

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_last;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_peer_hit;

  logic [IDX_W-1:0]     w_hi_sel, w_lo_sel, w_sel;
  logic                 w_hi_found, w_lo_found, w_any;
  logic [NUM_CORES-1:0] w_self, w_peer_mask, w_flush_mask;
  logic [DATA_W-1:0]    w_peer_data, w_flush_data;
  logic [1:0]           w_req_op;
  logic [ADDR_W-1:0]    w_req_addr;

  // Round-robin: lowest requester above the last grant, else lowest at/below it.
  always_comb begin
    w_hi_sel   = '0;
    w_lo_sel   = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (req_core[i]) begin
        if (IDX_W'(i) > r_last) begin
          w_hi_sel   = IDX_W'(i);
          w_hi_found = 1'b1;
        end else begin
          w_lo_sel   = IDX_W'(i);
          w_lo_found = 1'b1;
        end
      end
    end
    w_sel = w_hi_found ? w_hi_sel : w_lo_sel;
    w_any = w_hi_found | w_lo_found;
  end

  assign w_self       = NUM_CORES'(1) << r_idx;
  assign w_peer_mask  = snoop_hit_in & ~w_self;
  assign w_flush_mask = flush_in & ~w_self;

  always_comb begin
    w_peer_data  = '0;
    w_flush_data = '0;
    w_req_op     = OP_NONE;
    w_req_addr   = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_peer_mask[i])  w_peer_data  = snoop_data_in[i*DATA_W +: DATA_W];
      if (w_flush_mask[i]) w_flush_data = snoop_data_in[i*DATA_W +: DATA_W];
      if (IDX_W'(i) == r_idx) begin
        w_req_op   = core_op_in[2*i +: 2];
        w_req_addr = core_addr_in[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_last     <= IDX_W'(NUM_CORES - 1);
      r_op       <= OP_NONE;
      r_addr     <= '0;
      r_data     <= '0;
      r_peer_hit <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx   <= w_sel;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_op   <= w_req_op;
          r_addr <= w_req_addr;
          if (w_req_op == OP_NONE) begin
            r_last  <= r_idx;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_SNOOP;
          end
        end
        S_SNOOP: begin
          r_peer_hit <= |w_peer_mask;
          if (r_op == OP_UPGR) begin
            r_data  <= '0;
            r_state <= S_RESP;
          end else if (|w_peer_mask) begin
            r_data  <= w_peer_data;
            r_state <= S_RESP;
          end else begin
            r_state <= S_L2_WAIT;
          end
        end
        S_L2_WAIT: begin
          if (l2_rd_valid) begin
            r_data  <= l2_rd_data;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_last  <= r_idx;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (r_state != S_IDLE);
    grant          = busy ? w_self : '0;
    snoop_op_out   = '1;
    snoop_addr_out = (r_state == S_SNOOP) ? r_addr : '0;
    resp_data_out  = '0;
    resp_hit_out   = '0;
    l2_rd_req      = (r_state == S_L2_WAIT);
    l2_wr_en       = (r_state == S_SNOOP) && (|w_flush_mask);
    l2_wr_data     = l2_wr_en ? w_flush_data : '0;
    l2_addr        = (l2_wr_en || l2_rd_req) ? r_addr : '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (r_state == S_SNOOP && IDX_W'(i) != r_idx) snoop_op_out[2*i +: 2] = r_op;
      if (r_state == S_RESP && IDX_W'(i) == r_idx) begin
        resp_data_out[i*DATA_W +: DATA_W] = r_data;
        resp_hit_out[2*i +: 2] = (r_op == OP_RD && r_peer_hit) ? 2'b01 : 2'b10;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mesi_bus_controller.sv
`default_nettype none
// tb_mesi_bus_controller: vector table plus corner sequences; responses scored from a queue.
// Rev 1.0 - initial release.
module tb_mesi_bus_controller;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_core;
  logic [2*N-1:0]  core_op_in;
  logic [AW*N-1:0] core_addr_in;
  logic [N-1:0]    grant;
  logic [2*N-1:0]  snoop_op_out;
  logic [AW-1:0]   snoop_addr_out;
  logic [N-1:0]    snoop_hit_in;
  logic [DW*N-1:0] snoop_data_in;
  logic [N-1:0]    flush_in;
  logic [DW*N-1:0] resp_data_out;
  logic [2*N-1:0]  resp_hit_out;
  logic            l2_rd_req, l2_wr_en, l2_rd_valid, busy;
  logic [AW-1:0]   l2_addr;
  logic [DW-1:0]   l2_wr_data, l2_rd_data;

  mesi_bus_controller #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req_core(req_core), .core_op_in(core_op_in),
    .core_addr_in(core_addr_in), .grant(grant), .snoop_op_out(snoop_op_out),
    .snoop_addr_out(snoop_addr_out), .snoop_hit_in(snoop_hit_in),
    .snoop_data_in(snoop_data_in), .flush_in(flush_in), .resp_data_out(resp_data_out),
    .resp_hit_out(resp_hit_out), .l2_rd_req(l2_rd_req), .l2_wr_en(l2_wr_en),
    .l2_addr(l2_addr), .l2_wr_data(l2_wr_data), .l2_rd_valid(l2_rd_valid),
    .l2_rd_data(l2_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [1:0]  hit;
    logic [1:0]  flush;
    logic [31:0] d0;
    logic [31:0] d1;
    int          lat;
    logic [31:0] l2d;
    logic [31:0] exp_data;
    logic [1:0]  exp_hit;
    int          exp_rd;
    bit          exp_wr;
    logic [31:0] exp_wr_data;
  } vec_t;

  typedef struct {
    int          core;
    logic [31:0] data;
    logic [1:0]  hit;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   l2_lat   = 0;
  int   l2_cnt   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // L2 model: raises valid on the l2_lat-th cycle of a read request (never if 0).
  always @(negedge clk) begin
    if (l2_rd_req) begin
      l2_cnt++;
      l2_rd_valid = (l2_lat != 0) && (l2_cnt == l2_lat);
    end else begin
      l2_cnt = 0;
      l2_rd_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && resp_hit_out != '0) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 64'(resp_hit_out), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("resp_hit", 64'(resp_hit_out), 64'(e.hit) << (2 * e.core));
        chk("resp_data", 64'(resp_data_out[e.core*DW +: DW]), 64'(e.data));
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'(0));
    chk({tag, "_snoop_op"}, 64'(snoop_op_out), 64'(4'hF));
    chk({tag, "_resp_hit"}, 64'(resp_hit_out), 64'(0));
    chk({tag, "_resp_data"}, 64'(resp_data_out), 64'(0));
    chk({tag, "_l2"}, 64'({l2_rd_req, l2_wr_en}), 64'(0));
    chk({tag, "_l2_addr"}, 64'(l2_addr), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic run_txn(input vec_t v);
    int cyc = 0, rd_cyc = 0, wr_cnt = 0, snp_cyc = 0, bad_req = 0;
    int peer = 1 - v.core;
    logic [31:0] wr_addr = '0, wr_data = '0;
    bit done = 1'b0;
    @(negedge clk);
    snoop_hit_in  = v.hit;
    flush_in      = v.flush;
    snoop_data_in = {v.d1, v.d0};
    l2_lat        = v.lat;
    l2_rd_data    = v.l2d;
    core_op_in    = '1;
    core_op_in[v.core*2 +: 2] = v.op;
    core_addr_in  = '0;
    core_addr_in[v.core*AW +: AW] = v.addr;
    req_core      = '0;
    req_core[v.core] = 1'b1;
    sb.push_back('{v.core, v.exp_data, v.exp_hit});
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (grant[v.core]) req_core[v.core] = 1'b0;
      if (l2_rd_req) rd_cyc++;
      if (l2_wr_en) begin
        wr_cnt++;
        wr_addr = l2_addr;
        wr_data = l2_wr_data;
      end
      if (snoop_op_out[peer*2 +: 2] == v.op) snp_cyc++;
      if (snoop_op_out[v.core*2 +: 2] != 2'b11) bad_req++;
      if (resp_hit_out != '0) done = 1'b1;
    end
    chk("resp_timeout", 64'(done), 64'(1));
    chk("latency", 64'(cyc), 64'(3 + v.exp_rd));
    chk("l2_rd_cycles", 64'(rd_cyc), 64'(v.exp_rd));
    chk("l2_wr_count", 64'(wr_cnt), 64'(v.exp_wr));
    if (v.exp_wr) begin
      chk("l2_wr_addr", 64'(wr_addr), 64'(v.addr));
      chk("l2_wr_data", 64'(wr_data), 64'(v.exp_wr_data));
    end
    chk("peer_snoop_cycles", 64'(snp_cyc), 64'(1));
    chk("requester_snoop_11", 64'(bad_req), 64'(0));
    @(negedge clk);
    chk("busy_after_resp", 64'(busy), 64'(0));
    snoop_hit_in = '0;
    flush_in     = '0;
  endtask

  vec_t vecs[8];

  initial begin
    int cyc, gaps, bad, grants;
    logic [N-1:0] prev;
    int gq[$];

    vecs[0] = '{0, 2'b00, 32'h0000_0104, 2'b00, 2'b00, 32'h0, 32'h0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10, 3, 1'b0, 32'h0};
    vecs[1] = '{1, 2'b00, 32'h0000_0104, 2'b01, 2'b01, 32'h1234_5678, 32'h0, 0, 32'h0, 32'h1234_5678, 2'b01, 0, 1'b1, 32'h1234_5678};
    vecs[2] = '{0, 2'b01, 32'h0000_0200, 2'b10, 2'b00, 32'h0, 32'h1111_1111, 0, 32'h0, 32'h0, 2'b10, 0, 1'b0, 32'h0};
    vecs[3] = '{1, 2'b10, 32'h0000_0300, 2'b01, 2'b00, 32'hA5A5_0001, 32'h0, 0, 32'h0, 32'hA5A5_0001, 2'b10, 0, 1'b0, 32'h0};
    vecs[4] = '{0, 2'b10, 32'h0000_0400, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 2'b10, 1, 1'b0, 32'h0};
    vecs[5] = '{1, 2'b00, 32'h0000_0500, 2'b10, 2'b10, 32'h0, 32'h7777_7777, 2, 32'h55AA_55AA, 32'h55AA_55AA, 2'b10, 2, 1'b0, 32'h0};
    vecs[6] = '{0, 2'b00, 32'h0000_0600, 2'b10, 2'b00, 32'h0, 32'hCAFE_F00D, 0, 32'h0, 32'hCAFE_F00D, 2'b01, 0, 1'b0, 32'h0};
    vecs[7] = '{0, 2'b10, 32'h0000_0700, 2'b10, 2'b10, 32'h0, 32'h89AB_CDEF, 0, 32'h0, 32'h89AB_CDEF, 2'b10, 0, 1'b1, 32'h89AB_CDEF};

    reset = 1'b1; req_core = '0; core_op_in = '1; core_addr_in = '0;
    snoop_hit_in = '0; snoop_data_in = '0; flush_in = '0;
    l2_rd_valid = 1'b0; l2_rd_data = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("idle");

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));

    // Both cores silent-hit continuously: grants alternate from core 0 after reset.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    core_op_in = '1; req_core = 2'b11;
    for (int k = 0; k < 6; k++) gq.push_back(k % 2);
    cyc = 0; bad = 0; gaps = 0; prev = '0;
    while (gq.size() != 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (snoop_op_out != 4'hF) bad++;
      if (grant != '0) begin
        if (prev != '0) gaps++;
        chk("rr_grant", 64'(grant), 64'(1) << gq.pop_front());
      end
      prev = grant;
    end
    req_core = '0;
    chk("rr_timeout", 64'(gq.size()), 64'(0));
    chk("rr_no_snoop", 64'(bad), 64'(0));
    chk("rr_idle_gap", 64'(gaps), 64'(0));
    repeat (2) @(negedge clk);

    // Single requester: one grant every other cycle.
    req_core = 2'b01; grants = 0; gaps = 0; prev = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (grant != '0) begin
        grants++;
        if (prev != '0) gaps++;
      end
      prev = grant;
    end
    req_core = '0;
    chk("single_grants", 64'(grants), 64'(5));
    chk("single_gap", 64'(gaps), 64'(0));
    repeat (2) @(negedge clk);

    // Reset while waiting on an L2 read that never returns.
    l2_lat = 0;
    core_op_in = '1; core_op_in[1:0] = 2'b00; core_addr_in = '0; core_addr_in[31:0] = 32'h800;
    req_core = 2'b01; cyc = 0;
    while (!l2_rd_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (grant[0]) req_core = '0;
    end
    chk("rst_reach_l2wait", 64'(l2_rd_req), 64'(1));
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check_idle("rst_mid");
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (l2_wr_en || busy || l2_rd_req) bad++;
    end
    chk("rst_no_l2_after", 64'(bad), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mesi_bus_controller.md
Name: mesi_bus_controller

Overview:
- Shared-bus responder and arbiter for the MESI snooping L1 caches.
- Arbitrates the cores' req_core lines round-robin and grants one core at a time.
- Latches the granted core's bus operation, broadcasts it as a snoop to all other cores, and collects their hit/flush responses.
- Sources line data from a peer L1 or from L2, then returns data and a shared/exclusive hit code to the requester.

Parameters:
NUM_CORES, 2, number of L1 requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data word width

Ports:
clk  in  1  clock
reset  in  1  reset
req_core  in  NUM_CORES  per-core bus request
core_op_in  in  2*NUM_CORES  per-core bus op: 00 BusRd, 01 BusUpgr, 10 BusRdX, 11 none
core_addr_in  in  ADDR_W*NUM_CORES  per-core bus address
grant  out  NUM_CORES  one-hot grant
snoop_op_out  out  2*NUM_CORES  per-core snoop op; 11 when idle and to the requester
snoop_addr_out  out  ADDR_W  snooped address
snoop_hit_in  in  NUM_CORES  peer holds a valid matching line
snoop_data_in  in  DATA_W*NUM_CORES  peer line data
flush_in  in  NUM_CORES  peer line is M/E and must be written to L2
resp_data_out  out  DATA_W*NUM_CORES  data to each core
resp_hit_out  out  2*NUM_CORES  00 none, 01 shared (peer had line), 10 exclusive (no peer)
l2_rd_req  out  1  L2 read request
l2_wr_en  out  1  L2 write strobe (flush)
l2_addr  out  ADDR_W  L2 address
l2_wr_data  out  DATA_W  flush data
l2_rd_valid  in  1  L2 read data valid
l2_rd_data  in  DATA_W  L2 read data
busy  out  1  transaction in progress

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. FSM returns to IDLE from any state. Round-robin pointer is set so core 0 has top priority.
- Outputs at reset and in IDLE: grant=0, snoop_op_out all 11, resp_*=0, l2_*=0, busy=0.
- Reset mid-transaction abandons it. No L2 write is issued after reset.
- States: IDLE, GRANT, SNOOP, L2_WAIT, RESP.
- IDLE:
  - If any req_core is high, select the first requester after the last granted index (wrap at NUM_CORES-1 to 0).
  - Latch its index; go to GRANT.
  - Requests arriving while not IDLE are held off; they are not queued beyond the req level.
- GRANT (1 cycle): grant[idx]=1, busy=1.
  - Latch core_op_in[idx] and core_addr_in[idx]; the L1 drives these combinationally under grant.
  - Latched op 11 (silent M/E/S hit): go to IDLE, update pointer, no response.
  - Otherwise go to SNOOP.
- SNOOP (1 cycle): grant held.
  - snoop_op_out = latched op to every core except idx; requester sees 11. snoop_addr_out = latched address.
  - Sample snoop_hit_in and flush_in from non-requesters only.
  - Peer data = lowest-index hitting peer.
  - Any flush: l2_wr_en=1 for this cycle, l2_addr = latched address, l2_wr_data = flushing peer's data (lowest index).
  - Next state:
    - BusUpgr goes to RESP, no data.
    - BusRd/BusRdX with a peer hit goes to RESP with peer data.
    - Otherwise goes to L2_WAIT.
- L2_WAIT: grant held; l2_rd_req=1, l2_addr = latched address. On l2_rd_valid, capture l2_rd_data and go to RESP. No timeout.
- RESP (1 cycle): grant held.
  - resp_data_out[idx] = captured data.
  - resp_hit_out[idx]:
    - BusRd: 01 if peer hit, else 10.
    - BusRdX/Upgr: 10.
  - Other cores' resp_hit=00. Next state IDLE; pointer = idx.
- Requester dropping req_core after GRANT: transaction still completes.
- Single requester: re-granted each transaction, with a minimum 1 IDLE cycle between grants.
- Latency, BusRd peer hit: 4 cycles from req to RESP (IDLE, GRANT, SNOOP, RESP).

Test Plan:
- Reset: assert reset in L2_WAIT -> next cycle grant=0, l2_rd_req=0, busy=0, snoop_op_out all 11.
- Core0 BusRd 0x0000_0104, no peer hit, L2 returns 0xDEADBEEF after 3 cycles -> l2_rd_req high 3 cycles; RESP gives resp_data_out[0]=0xDEADBEEF, resp_hit_out[0]=10.
- Core1 BusRd 0x104, core0 snoop_hit=1, flush=1, data 0x12345678 -> l2_wr_en pulse with 0x12345678 at 0x104; resp_data_out[1]=0x12345678, resp_hit=01; l2_rd_req never asserted.
- Core0 BusUpgr 0x200 -> core1 sees snoop_op 01 for exactly one cycle; resp_hit_out[0]=10; no L2 traffic.
- Both cores request continuously, each op 11 -> grants alternate 0,1,0,1; no snoop ops issued.
- Core1 BusRdX while core0 holds S copy (hit, no flush) -> snoop_op 10 to core0; no L2 write; data from core0; resp_hit_out[1]=10.
